aurora_tx_frame_arbiter: RTL and testbench

//  Shares the single Aurora 8b10b AXI4-Stream TX channel (s_axi_tx_*) between two frame sources.

---
 rtl/aurora_tx_frame_arbiter_if.sv | 13 +
 rtl/aurora_tx_frame_arbiter.sv | 142 ++++++++++++++
 tb/tb_aurora_tx_frame_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aurora_tx_frame_arbiter_if.sv
// AXI4-Stream style frame channel shared by the TX arbiter's sources and its Aurora-facing output.
// Data uses Aurora ordering: bit 0 is the MSB.
interface aurora_tx_frame_arbiter_if #(
   parameter int unsigned DATA_W = 32
);
   logic [0:DATA_W-1] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aurora_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one Aurora 8b10b TX stream between two sources.
// Caps frame length, counts completed frames and drains sources whose frame was cut by link loss.
module aurora_tx_frame_arbiter #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_WORDS = 256,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       channel_up,
   aurora_tx_frame_arbiter_if.slave   s0,
   aurora_tx_frame_arbiter_if.slave   s1,
   aurora_tx_frame_arbiter_if.master  m,
   output logic [1:0]                 grant,
   output logic [CNT_W-1:0]           frame_cnt0,
   output logic [CNT_W-1:0]           frame_cnt1,
   output logic                       err_len,
   output logic                       err_abort,
   input  logic                       err_clr
);
   localparam int unsigned WcW = $clog2(MAX_WORDS + 1);

   typedef enum logic [1:0] {StIdle, StBusy, StFlush} state_e;

   state_e             state_q, state_d;
   logic [1:0]         grant_q, grant_d;
   logic               last_q, last_d;
   logic [WcW-1:0]     word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic               err_len_q, err_len_d, err_abort_q, err_abort_d;

   logic               sel, sg_tvalid, sg_tlast, sg_tready, at_max, beat, winner;
   logic [0:DATA_W-1]  sg_tdata;

   assign sel       = grant_q[1];
   assign sg_tdata  = sel ? s1.tdata  : s0.tdata;
   assign sg_tvalid = sel ? s1.tvalid : s0.tvalid;
   assign sg_tlast  = sel ? s1.tlast  : s0.tlast;
   assign at_max    = (word_cnt_q == WcW'(MAX_WORDS - 1));
   assign beat      = m.tvalid & m.tready;
   // 1 selects source 1; on contention the source that did not win last time goes next
   assign winner    = (s0.tvalid & s1.tvalid) ? ~last_q : s1.tvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         grant_q     <= 2'b00;
         last_q      <= 1'b1;
         word_cnt_q  <= '0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
         err_len_q   <= 1'b0;
         err_abort_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         word_cnt_q  <= word_cnt_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
         err_len_q   <= err_len_d;
         err_abort_q <= err_abort_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      word_cnt_d  = word_cnt_q;
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;
      err_len_d   = err_len_q & ~err_clr;
      err_abort_d = err_abort_q & ~err_clr;
      case (state_q)
         StIdle: begin
            if (channel_up && (s0.tvalid || s1.tvalid)) begin
               grant_d    = winner ? 2'b10 : 2'b01;
               last_d     = winner;
               word_cnt_d = '0;
               state_d    = StBusy;
            end
         end
         StBusy: begin
            if (!channel_up) begin
               err_abort_d = 1'b1;
               if (sg_tvalid && sg_tlast) begin
                  grant_d = 2'b00;
                  state_d = StIdle;
               end else begin
                  state_d = StFlush;
               end
            end else if (beat) begin
               word_cnt_d = word_cnt_q + 1'b1;
               if (sg_tlast || at_max) begin
                  if (sel) cnt1_d = cnt1_q + 1'b1;
                  else     cnt0_d = cnt0_q + 1'b1;
                  if (sg_tlast) begin
                     grant_d = 2'b00;
                     state_d = StIdle;
                  end else begin
                     err_len_d = 1'b1;
                     state_d   = StFlush;
                  end
               end
            end
         end
         StFlush: begin
            if (sg_tvalid && sg_tlast) begin
               grant_d = 2'b00;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      m.tdata   = sg_tdata;
      m.tvalid  = 1'b0;
      m.tlast   = 1'b0;
      sg_tready = 1'b0;
      case (state_q)
         StBusy: begin
            m.tvalid  = sg_tvalid & channel_up;
            m.tlast   = sg_tlast | at_max;
            // On link loss the cut word is swallowed so a trailing tlast ends the frame here
            sg_tready = channel_up ? m.tready : 1'b1;
         end
         StFlush: sg_tready = 1'b1;
         default: sg_tready = 1'b0;
      endcase
      s0.tready = sg_tready & grant_q[0];
      s1.tready = sg_tready & grant_q[1];
   end

   assign grant      = grant_q;
   assign frame_cnt0 = cnt0_q;
   assign frame_cnt1 = cnt1_q;
   assign err_len    = err_len_q;
   assign err_abort  = err_abort_q;
endmodule

// File: tb/tb_aurora_tx_frame_arbiter.sv
// Randomised bench for aurora_tx_frame_arbiter: frame queues per source, a per-source expected
// output scoreboard and frame-level counters/flags derived from frame lengths.
module tb_aurora_tx_frame_arbiter;
   localparam int unsigned DW   = 32;
   localparam int unsigned MAXW = 20;
   localparam int unsigned CW   = 4;

   typedef struct packed {
      logic [0:DW-1] data;
      logic          last;
   } word_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          channel_up = 1'b0;
   logic          err_clr = 1'b0;
   logic [1:0]    grant;
   logic [CW-1:0] frame_cnt0, frame_cnt1;
   logic          err_len, err_abort;

   aurora_tx_frame_arbiter_if #(.DATA_W(DW)) s0_if ();
   aurora_tx_frame_arbiter_if #(.DATA_W(DW)) s1_if ();
   aurora_tx_frame_arbiter_if #(.DATA_W(DW)) m_if ();

   aurora_tx_frame_arbiter #(.DATA_W(DW), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .channel_up (channel_up),
      .s0         (s0_if),
      .s1         (s1_if),
      .m          (m_if),
      .grant      (grant),
      .frame_cnt0 (frame_cnt0),
      .frame_cnt1 (frame_cnt1),
      .err_len    (err_len),
      .err_abort  (err_abort),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   word_t      src_q [2][$];
   word_t      exp_q [2][$];
   int         n_acc [2];
   int         exp_cnt [2];
   logic       exp_err_len = 1'b0;
   int         vpct = 100;
   int         tready_mode = 0;
   int         cyc = 0;
   int         n_beats = 0;
   logic       in_frame = 1'b0;
   logic       cur_src = 1'b0;
   logic [1:0] grant_prev = 2'b00;
   logic [1:0] grant_log [$];
   int         beat_cyc [$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Queue a frame on source k; n_exp < 0 means the frame is expected to complete normally.
   task automatic push_frame(input int k, input int len, input int fid, input int n_exp);
      word_t w;
      int    n_out;
      n_out = (len > int'(MAXW)) ? int'(MAXW) : len;
      for (int i = 0; i < len; i++) begin
         w.data = {k[0], fid[6:0], 24'(i * 4)};
         w.last = (i == len - 1);
         src_q[k].push_back(w);
         if (n_exp < 0 && i < n_out) begin
            w.last = (i == n_out - 1);
            exp_q[k].push_back(w);
         end else if (i < n_exp) begin
            w.last = 1'b0;
            exp_q[k].push_back(w);
         end
      end
      if (n_exp < 0) begin
         exp_cnt[k]++;
         if (len > int'(MAXW)) exp_err_len = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
             && n < 20000) begin
         @(posedge clk);
         n++;
      end
      check_val(tag, 64'(n < 20000), 64'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q[0].delete();
      exp_q[1].delete();
      exp_cnt[0]  = 0;
      exp_cnt[1]  = 0;
      exp_err_len = 1'b0;
      in_frame    = 1'b0;
      grant_prev  = 2'b00;
      rst_n       = 1'b1;
   endtask

   task automatic pulse_err_clr();
      step();
      err_clr = 1'b1;
      step();
      err_clr     = 1'b0;
      exp_err_len = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_grant"}, 64'(grant), 64'd0);
      check_val({tag, "_m_tvalid"}, 64'(m_if.tvalid), 64'd0);
      check_val({tag, "_m_tlast"}, 64'(m_if.tlast), 64'd0);
      check_val({tag, "_s0_tready"}, 64'(s0_if.tready), 64'd0);
      check_val({tag, "_s1_tready"}, 64'(s1_if.tready), 64'd0);
      check_val({tag, "_cnt0"}, 64'(frame_cnt0), 64'd0);
      check_val({tag, "_cnt1"}, 64'(frame_cnt1), 64'd0);
      check_val({tag, "_err_len"}, 64'(err_len), 64'd0);
      check_val({tag, "_err_abort"}, 64'(err_abort), 64'd0);
   endtask

   task automatic check_counts(input string tag);
      check_val({tag, "_cnt0"}, 64'(frame_cnt0), 64'(exp_cnt[0] % (1 << CW)));
      check_val({tag, "_cnt1"}, 64'(frame_cnt1), 64'(exp_cnt[1] % (1 << CW)));
   endtask

   // Source and sink driver: handshakes sampled on the falling edge, inputs updated after rising.
   initial begin : driver
      logic  hs0, hs1;
      word_t w;
      s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
      s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
      m_if.tready  = 1'b0;
      n_acc[0] = 0;
      n_acc[1] = 0;
      forever begin
         @(negedge clk);
         hs0 = s0_if.tvalid & s0_if.tready;
         hs1 = s1_if.tvalid & s1_if.tready;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            src_q[0].delete();
            src_q[1].delete();
            s0_if.tvalid = 1'b0;
            s1_if.tvalid = 1'b0;
         end else begin
            if (hs0) begin void'(src_q[0].pop_front()); n_acc[0]++; end
            if (hs1) begin void'(src_q[1].pop_front()); n_acc[1]++; end
            s0_if.tvalid = (s0_if.tvalid & ~hs0) |
                           (src_q[0].size() > 0 && int'($urandom_range(0, 99)) < vpct);
            s1_if.tvalid = (s1_if.tvalid & ~hs1) |
                           (src_q[1].size() > 0 && int'($urandom_range(0, 99)) < vpct);
            if (src_q[0].size() > 0) begin
               w = src_q[0][0];
               s0_if.tdata = w.data;
               s0_if.tlast = w.last;
            end
            if (src_q[1].size() > 0) begin
               w = src_q[1][0];
               s1_if.tdata = w.data;
               s1_if.tlast = w.last;
            end
         end
         case (tready_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = 1'($urandom_range(0, 1));
            default: m_if.tready = ~m_if.tready;
         endcase
      end
   end

   logic  mk, mhave;
   word_t me;

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (grant !== grant_prev) grant_log.push_back(grant);
         grant_prev = grant;
         if (!channel_up) check_val("no_link_tvalid", 64'(m_if.tvalid), 64'd0);
         if (m_if.tvalid && m_if.tready) begin
            mk    = m_if.tdata[0];
            me    = '0;
            mhave = 1'b0;
            if (exp_q[mk].size() > 0) begin
               me    = exp_q[mk].pop_front();
               mhave = 1'b1;
            end
            check_val("beat", 64'({mhave, m_if.tlast, m_if.tdata}),
                      64'({1'b1, me.last, me.data}));
            if (in_frame) check_val("frame_src", 64'(mk), 64'(cur_src));
            in_frame = ~m_if.tlast;
            cur_src  = mk;
            n_beats++;
            beat_cyc.push_back(cyc);
         end
      end
   end

   initial begin : main
      int         n, base_beats, base_acc;
      logic [1:0] gexp;
      do_reset();
      @(negedge clk);
      check_reset("rst");

      // No link: a waiting source must never be granted
      step();
      vpct        = 100;
      tready_mode = 0;
      push_frame(0, 19, 0, -1);
      repeat (100) begin
         @(negedge clk);
         check_val("t1_grant", 64'(grant), 64'd0);
         check_val("t1_s0_tready", 64'(s0_if.tready), 64'd0);
      end

      step();
      grant_log.delete();
      channel_up = 1'b1;
      wait_drain("t2_drain");
      check_val("t2_beats", 64'(n_beats), 64'd19);
      check_counts("t2");
      check_val("t2_glog_n", 64'(grant_log.size()), 64'd2);
      check_val("t2_glog0", 64'(grant_log.size() > 0 ? grant_log[0] : 2'b11), 64'd1);
      check_val("t2_glog1", 64'(grant_log.size() > 1 ? grant_log[1] : 2'b11), 64'd0);

      // Both sources saturated: strict alternation with one idle cycle between frames
      do_reset();
      grant_log.delete();
      beat_cyc.delete();
      for (int f = 0; f < 3; f++) begin
         push_frame(0, 3, 10 + f, -1);
         push_frame(1, 3, 20 + f, -1);
      end
      wait_drain("t3_drain");
      check_val("t3_glog_n", 64'(grant_log.size()), 64'd12);
      for (int i = 0; i < 12; i++) begin
         gexp = (i % 2 == 1) ? 2'b00 : ((i % 4 == 0) ? 2'b01 : 2'b10);
         check_val($sformatf("t3_glog%0d", i),
                   64'(i < grant_log.size() ? grant_log[i] : 2'b11), 64'(gexp));
      end
      check_val("t3_nbeats", 64'(beat_cyc.size()), 64'd18);
      check_val("t3_span", 64'(beat_cyc.size() > 0 ? beat_cyc[$] - beat_cyc[0] : 0), 64'd22);
      check_counts("t3");

      // Length limit: exactly MAXW is legal, longer is truncated and the rest drained
      pulse_err_clr();
      push_frame(0, MAXW, 30, -1);
      wait_drain("t4a_drain");
      check_val("t4_exact_err_len", 64'(err_len), 64'd0);
      base_acc   = n_acc[1];
      base_beats = n_beats;
      push_frame(1, MAXW + 4, 31, -1);
      wait_drain("t4b_drain");
      check_val("t4_err_len", 64'(err_len), 64'd1);
      check_val("t4_acc", 64'(n_acc[1] - base_acc), 64'(MAXW + 4));
      check_val("t4_beats", 64'(n_beats - base_beats), 64'(MAXW));
      check_counts("t4");

      // Random traffic with random gaps and backpressure
      pulse_err_clr();
      vpct        = 70;
      tready_mode = 1;
      for (int i = 0; i < 40; i++) begin
         push_frame(int'($urandom_range(0, 1)), int'($urandom_range(1, MAXW + 4)), 40 + i, -1);
      end
      wait_drain("rnd_drain");
      check_counts("rnd");
      check_val("rnd_err_len", 64'(err_len), 64'(exp_err_len));
      check_val("rnd_err_abort", 64'(err_abort), 64'd0);

      // Link loss after the fifth beat
      pulse_err_clr();
      vpct        = 100;
      tready_mode = 0;
      base_acc    = n_acc[0];
      base_beats  = n_beats;
      push_frame(0, 19, 90, 5);
      n = 0;
      while (n_beats - base_beats < 5 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      check_val("t5_reach5", 64'(n < 1000), 64'd1);
      #1;
      channel_up = 1'b0;
      wait_drain("t5_drain");
      in_frame = 1'b0;
      check_val("t5_err_abort", 64'(err_abort), 64'd1);
      check_val("t5_beats", 64'(n_beats - base_beats), 64'd5);
      check_val("t5_acc", 64'(n_acc[0] - base_acc), 64'd19);
      check_counts("t5");
      pulse_err_clr();
      @(negedge clk);
      check_val("t5_err_clr", 64'(err_abort), 64'd0);

      // Toggling backpressure, then asynchronous reset mid-frame
      step();
      channel_up  = 1'b1;
      tready_mode = 2;
      base_acc    = n_acc[1];
      push_frame(1, 10, 100, -1);
      wait_drain("t6_drain");
      check_val("t6_acc", 64'(n_acc[1] - base_acc), 64'd10);
      check_counts("t6");
      base_beats = n_beats;
      push_frame(0, 10, 101, -1);
      n = 0;
      while (n_beats - base_beats < 3 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      check_val("t6_reach3", 64'(n < 1000), 64'd1);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset("t6_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
